vga_clken_gen: RTL and testbench

VGA_CLKEN_GEN -- requirements
Module: vga_clken_gen

---
 rtl/vga_clk_pkg.sv | 18 +
 rtl/vga_clken_nco.sv | 51 +++++
 rtl/vga_clken_gen.sv | 100 ++++++++++
 tb/tb_vga_clken_gen.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/vga_clk_pkg.sv
// Shared types and defaults for the VGA clock-enable generator.
package vga_clk_pkg;

  localparam int unsigned ACC_W_DEF   = 16;
  localparam int unsigned INC_RST_DEF = 16384;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOCKING = 2'd1,
    ST_LOCKED  = 2'd2
  } state_e;

  // Width of the channel-select port; a single channel still gets one bit.
  function automatic int unsigned ch_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vga_clken_nco.sv
// One phase accumulator with a registered carry-out used as a clock enable.
module vga_clken_nco #(
  parameter int unsigned ACC_W   = 16,
  parameter int unsigned INC_RST = 16384
) (
  input  logic             refclk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             run_ok,
  input  logic             load,
  input  logic [ACC_W-1:0] load_inc,
  input  logic [ACC_W-1:0] load_phase,
  output logic             clken
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] inc_q, inc_d;
  logic             clken_q, clken_d;
  logic [ACC_W:0]   sum;

  // Wrapping add; a load overrides the running accumulator and increment.
  always_comb begin
    sum     = {1'b0, acc_q} + {1'b0, inc_q};
    acc_d   = acc_q;
    inc_d   = inc_q;
    clken_d = 1'b0;
    if (load) begin
      acc_d = load_phase;
      inc_d = load_inc;
    end else if (en) begin
      acc_d   = sum[ACC_W-1:0];
      clken_d = sum[ACC_W] & run_ok;
    end
  end

  // Accumulator, increment and carry registers.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      inc_q   <= ACC_W'(INC_RST);
      clken_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      inc_q   <= inc_d;
      clken_q <= clken_d;
    end
  end

  assign clken = clken_q;

endmodule

// File: rtl/vga_clken_gen.sv
// Multi-channel NCO clock-enable generator with a lock/settle controller.
module vga_clken_gen
  import vga_clk_pkg::*;
#(
  parameter int unsigned N_CH     = 2,
  parameter int unsigned ACC_W    = ACC_W_DEF,
  parameter int unsigned INC_RST  = INC_RST_DEF,
  parameter int unsigned LOCK_CYC = 16
) (
  input  logic                    refclk,
  input  logic                    rst_n,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [ch_w(N_CH)-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]        cfg_inc,
  input  logic [ACC_W-1:0]        cfg_phase,
  input  logic [N_CH-1:0]         enable,
  output logic [N_CH-1:0]         clken,
  output logic                    locked
);

  localparam int unsigned CH_W   = ch_w(N_CH);
  localparam int unsigned LCNT_W = $clog2(LOCK_CYC);

  state_e              state_q, state_d;
  logic [LCNT_W-1:0]   lcnt_q, lcnt_d;
  logic                locked_q, locked_d;
  logic                cfg_ready_q, cfg_ready_d;
  logic                cfg_fire;
  logic                ch_ok;
  logic                run_ok;
  logic [N_CH-1:0]     load_vec;

  // Next-state, lock counter and per-channel load decode.
  always_comb begin
    state_d     = state_q;
    lcnt_d      = lcnt_q;
    cfg_fire    = cfg_valid & cfg_ready_q;
    ch_ok       = (32'(cfg_ch) < N_CH);
    for (int i = 0; i < N_CH; i++) begin
      load_vec[i] = cfg_fire & ch_ok & (cfg_ch == CH_W'(i));
    end
    case (state_q)
      ST_IDLE: begin
        state_d = ST_LOCKING;
        lcnt_d  = LCNT_W'(LOCK_CYC - 1);
      end
      ST_LOCKING: begin
        if (lcnt_q == '0) state_d = ST_LOCKED;
        else              lcnt_d  = lcnt_q - LCNT_W'(1);
      end
      ST_LOCKED: begin
        // Out-of-range channel writes are accepted but ignored.
        if (cfg_fire && ch_ok) begin
          state_d = ST_LOCKING;
          lcnt_d  = LCNT_W'(LOCK_CYC - 1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    run_ok      = (state_d == ST_LOCKED);
    locked_d    = run_ok;
    cfg_ready_d = run_ok;
  end

  // Control state and registered status outputs.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      lcnt_q      <= '0;
      locked_q    <= 1'b0;
      cfg_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lcnt_q      <= lcnt_d;
      locked_q    <= locked_d;
      cfg_ready_q <= cfg_ready_d;
    end
  end

  assign locked    = locked_q;
  assign cfg_ready = cfg_ready_q;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    vga_clken_nco #(
      .ACC_W   (ACC_W),
      .INC_RST (INC_RST)
    ) u_nco (
      .refclk     (refclk),
      .rst_n      (rst_n),
      .en         (enable[i]),
      .run_ok     (run_ok),
      .load       (load_vec[i]),
      .load_inc   (cfg_inc),
      .load_phase (cfg_phase),
      .clken      (clken[i])
    );
  end

endmodule

// File: tb/tb_vga_clken_gen.sv
// Directed bench for vga_clken_gen (two-channel default build plus a three-channel build).
module tb_vga_clken_gen;

  logic        refclk = 1'b0;
  always #5 refclk = ~refclk;

  logic        rst_n, cfg_valid, cfg_ready, locked, cfg_ch;
  logic [15:0] cfg_inc, cfg_phase;
  logic [1:0]  enable, clken;

  logic        rst3_n, cfg_valid3, cfg_ready3, locked3;
  logic [1:0]  cfg_ch3;
  logic [15:0] cfg_inc3, cfg_phase3;
  logic [2:0]  enable3, clken3;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n0, n1;

  vga_clken_gen u_dut (
    .refclk    (refclk),
    .rst_n     (rst_n),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_inc   (cfg_inc),
    .cfg_phase (cfg_phase),
    .enable    (enable),
    .clken     (clken),
    .locked    (locked)
  );

  vga_clken_gen #(.N_CH(3)) u_dut3 (
    .refclk    (refclk),
    .rst_n     (rst3_n),
    .cfg_valid (cfg_valid3),
    .cfg_ready (cfg_ready3),
    .cfg_ch    (cfg_ch3),
    .cfg_inc   (cfg_inc3),
    .cfg_phase (cfg_phase3),
    .enable    (enable3),
    .clken     (clken3),
    .locked    (locked3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge refclk);
    #1;
    cyc++;
  endtask

  initial begin
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_ch = 1'b0; cfg_inc = '0; cfg_phase = '0; enable = 2'b11;
    rst3_n = 1'b0; cfg_valid3 = 1'b0; cfg_ch3 = '0; cfg_inc3 = '0; cfg_phase3 = '0; enable3 = 3'b111;
    #23;
    chk("rst_clken", 32'(clken), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_ready", 32'(cfg_ready), 0);

    // Lock sequence from reset release, default increments (period 4)
    @(negedge refclk); rst_n = 1'b1; cyc = 0;
    for (int k = 1; k <= 28; k++) begin
      step();
      chk("lock_locked", 32'(locked), 32'(cyc >= 17));
      chk("lock_ready", 32'(cfg_ready), 32'(cyc >= 17));
      chk("lock_clken", 32'(clken), (cyc >= 17 && cyc % 4 == 0) ? 3 : 0);
    end

    // ch1: inc=0x2000 phase=0xF000 -> period 8, relock after 16
    cfg_valid = 1'b1; cfg_ch = 1'b1; cfg_inc = 16'h2000; cfg_phase = 16'hF000;
    step();
    cfg_valid = 1'b0;
    chk("wr1_locked", 32'(locked), 0);
    chk("wr1_ready", 32'(cfg_ready), 0);
    while (cyc < 64) begin
      step();
      chk("wr1_relock", 32'(locked), 32'(cyc >= 45));
      chk("wr1_ch0", 32'(clken[0]), 32'(cyc >= 45 && cyc % 4 == 0));
      chk("wr1_ch1", 32'(clken[1]), 32'(cyc >= 45 && (cyc - 30) % 8 == 0));
    end

    // ch1 inc=0 with cfg_valid held through LOCKING
    cfg_valid = 1'b1; cfg_ch = 1'b1; cfg_inc = 16'h0000; cfg_phase = 16'h0000;
    step();
    chk("hold_first", 32'(locked), 0);
    while (cyc < 81) begin
      step();
      chk("hold_ready", 32'(cfg_ready), 32'(cyc == 81));
      chk("hold_locked", 32'(locked), 32'(cyc == 81));
    end
    step();
    cfg_valid = 1'b0;
    chk("hold_xfer", 32'(locked), 0);
    while (cyc < 98) begin
      step();
      chk("hold_relock", 32'(locked), 32'(cyc >= 98));
    end
    n0 = 0; n1 = 0;
    repeat (1000) begin
      step();
      n0 += int'(clken[0]);
      n1 += int'(clken[1]);
    end
    chk("inc0_ch1", 32'(n1), 0);
    chk("inc0_ch0", 32'(n0), 250);

    // ch1 inc=0xFFFF
    cfg_valid = 1'b1; cfg_ch = 1'b1; cfg_inc = 16'hFFFF; cfg_phase = 16'h0000;
    step();
    cfg_valid = 1'b0;
    chk("incmax_drop", 32'(locked), 0);
    repeat (16) step();
    chk("incmax_relock", 32'(locked), 1);
    n0 = 0; n1 = 0;
    repeat (1000) begin
      step();
      n0 += int'(clken[0]);
      n1 += int'(clken[1]);
    end
    chk("incmax_lo", 32'(n1 >= 999), 1);
    chk("incmax_hi", 32'(n1 <= 1000), 1);
    chk("incmax_ch0", 32'(n0), 250);

    // Asynchronous reset while LOCKED and pulsing
    step();
    chk("pre_rst_locked", 32'(locked), 1);
    chk("pre_rst_ch1", 32'(clken[1]), 1);
    #3; rst_n = 1'b0; #1;
    chk("arst_clken", 32'(clken), 0);
    chk("arst_locked", 32'(locked), 0);
    chk("arst_ready", 32'(cfg_ready), 0);
    #7; rst_n = 1'b1; cyc = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      chk("rel_locked", 32'(locked), 32'(cyc >= 17));
      chk("rel_clken", 32'(clken), (cyc >= 17 && cyc % 4 == 0) ? 3 : 0);
    end

    // Asynchronous reset mid-LOCKING
    cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_inc = 16'h4000; cfg_phase = 16'h0000;
    step();
    cfg_valid = 1'b0;
    chk("mid_locking", 32'(locked), 0);
    repeat (5) step();
    #2; rst_n = 1'b0; #1;
    chk("arst2_clken", 32'(clken), 0);
    chk("arst2_locked", 32'(locked), 0);
    chk("arst2_ready", 32'(cfg_ready), 0);
    @(negedge refclk); rst_n = 1'b1; cyc = 0;
    repeat (16) step();
    chk("rel2_not_yet", 32'(locked), 0);
    step();
    chk("rel2_locked", 32'(locked), 1);

    // Three-channel build: write to non-existent channel 3 is consumed harmlessly
    @(negedge refclk); rst3_n = 1'b1; cyc = 0;
    repeat (17) step();
    chk("n3_locked", 32'(locked3), 1);
    cfg_valid3 = 1'b1; cfg_ch3 = 2'd3; cfg_inc3 = 16'h0000; cfg_phase3 = 16'h0000;
    step();
    cfg_valid3 = 1'b0;
    chk("n3_keep_locked", 32'(locked3), 1);
    chk("n3_keep_ready", 32'(cfg_ready3), 1);
    chk("n3_clken18", 32'(clken3), 0);
    while (cyc < 28) begin
      step();
      chk("n3_locked_run", 32'(locked3), 1);
      chk("n3_clken", 32'(clken3), (cyc % 4 == 0) ? 7 : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
